// File: rtl/button_events.sv
// Purpose: turns debounced button levels into PRESS/RELEASE/LONG/REPEAT events merged into one FIFO.
// Latency: event raised at edge N sits in its channel slot, enters the FIFO at N+1, evt_valid high after N+1.
// Backpressure: full FIFO parks events in 1-entry per-channel slots; a new event for a busy slot is dropped (sticky flag).
module button_events #(
  parameter int    WIDTH         = 6,
  parameter string POLARITY      = "LOW",
  parameter int    LONG_TIMEOUT  = 50000000,
  parameter int    REPEAT_PERIOD = 10000000,
  parameter int    COUNT_WIDTH   = 26,
  parameter int    FIFO_DEPTH    = 4,
  parameter int    CH_WIDTH      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    buttons_in,
  output logic [WIDTH-1:0]    pressed,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [CH_WIDTH-1:0] evt_channel,
  output logic [1:0]          evt_type,
  output logic                evt_dropped
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] LT_M1 = COUNT_WIDTH'(LONG_TIMEOUT - 1);
  localparam logic [COUNT_WIDTH-1:0] RP_M1 = COUNT_WIDTH'(REPEAT_PERIOD - 1);

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HELD} state_t;

  typedef struct packed {
    logic [CH_WIDTH-1:0] ch;
    logic [1:0]          typ;
  } evt_t;

  // Per-channel FSM state and hold counter
  state_t                 r_state     [WIDTH];
  logic [COUNT_WIDTH-1:0] r_cnt       [WIDTH];
  state_t                 w_state_nxt [WIDTH];
  logic [COUNT_WIDTH-1:0] w_cnt_nxt   [WIDTH];
  logic [WIDTH-1:0]       r_pressed;

  logic [WIDTH-1:0]       w_act;
  logic [WIDTH-1:0]       w_raise;
  logic [1:0]             w_raise_typ [WIDTH];

  // Pending slots and merge arbiter
  logic [WIDTH-1:0]       r_slot_vld;
  logic [1:0]             r_slot_typ  [WIDTH];
  logic                   w_any_slot;
  logic [CH_WIDTH-1:0]    w_grant_ch;
  logic [1:0]             w_grant_typ;
  logic [WIDTH-1:0]       w_grant_oh;
  logic [WIDTH-1:0]       w_drain;
  logic                   r_dropped;

  // Event FIFO; pointers carry one extra bit to tell full from empty
  evt_t                   r_mem [FIFO_DEPTH];
  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;
  logic [AW:0]            w_fill;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;

  assign w_act = (POLARITY == "LOW") ? ~buttons_in : buttons_in;

  // State register: FSM state, counters and the registered pressed level
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
      r_pressed <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_state[i]   <= w_state_nxt[i];
        r_cnt[i]     <= w_cnt_nxt[i];
        r_pressed[i] <= (w_state_nxt[i] != ST_IDLE);
      end
    end
  end

  // Next-state logic; release wins over LONG/REPEAT, counter saturates instead of wrapping
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_IDLE: begin
          if (w_act[i]) begin
            w_state_nxt[i] = ST_PRESSED;
            w_cnt_nxt[i]   = '0;
          end
        end
        ST_PRESSED: begin
          if (!w_act[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == LT_M1) begin
            w_state_nxt[i] = ST_HELD;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] != '1) begin
            w_cnt_nxt[i]   = r_cnt[i] + 1'b1;
          end
        end
        ST_HELD: begin
          if (!w_act[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_cnt_nxt[i]   = '0;
          end else if (REPEAT_PERIOD == 0) begin
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == RP_M1) begin
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] != '1) begin
            w_cnt_nxt[i]   = r_cnt[i] + 1'b1;
          end
        end
        default: begin
          w_state_nxt[i] = ST_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Output logic: which event, if any, each channel raises this cycle
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_raise[i]     = 1'b0;
      w_raise_typ[i] = EV_PRESS;
      case (r_state[i])
        ST_IDLE: begin
          if (w_act[i]) begin
            w_raise[i]     = 1'b1;
            w_raise_typ[i] = EV_PRESS;
          end
        end
        ST_PRESSED: begin
          if (!w_act[i]) begin
            w_raise[i]     = 1'b1;
            w_raise_typ[i] = EV_RELEASE;
          end else if (r_cnt[i] == LT_M1) begin
            w_raise[i]     = 1'b1;
            w_raise_typ[i] = EV_LONG;
          end
        end
        ST_HELD: begin
          if (!w_act[i]) begin
            w_raise[i]     = 1'b1;
            w_raise_typ[i] = EV_RELEASE;
          end else if ((REPEAT_PERIOD != 0) && (r_cnt[i] == RP_M1)) begin
            w_raise[i]     = 1'b1;
            w_raise_typ[i] = EV_REPEAT;
          end
        end
        default: ;
      endcase
    end
  end

  // Fixed-priority arbiter: lowest occupied slot index wins (scan high to low, last hit wins)
  always_comb begin
    w_any_slot  = 1'b0;
    w_grant_ch  = '0;
    w_grant_typ = EV_PRESS;
    w_grant_oh  = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_slot_vld[i]) begin
        w_any_slot  = 1'b1;
        w_grant_ch  = CH_WIDTH'(i);
        w_grant_typ = r_slot_typ[i];
        w_grant_oh  = '0;
        w_grant_oh[i] = 1'b1;
      end
    end
  end

  assign w_fill  = r_wr_ptr - r_rd_ptr;
  assign w_full  = w_fill[AW];
  assign w_empty = (w_fill == '0);
  assign w_push  = w_any_slot && !w_full;
  assign w_pop   = !w_empty && evt_ready;
  assign w_drain = w_push ? w_grant_oh : '0;

  // Pending slots: a slot drained this cycle may take a new event; otherwise a busy slot drops it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_vld <= '0;
      r_dropped  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_slot_typ[i] <= EV_PRESS;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_raise[i]) begin
          if (r_slot_vld[i] && !w_drain[i]) begin
            r_dropped <= 1'b1;
          end else begin
            r_slot_vld[i] <= 1'b1;
            r_slot_typ[i] <= w_raise_typ[i];
          end
        end else if (w_drain[i]) begin
          r_slot_vld[i] <= 1'b0;
        end
      end
    end
  end

  // Show-ahead FIFO; no push while full even if the head pops in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= '{ch: w_grant_ch, typ: w_grant_typ};
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign pressed     = r_pressed;
  assign evt_valid   = !w_empty;
  assign evt_channel = r_mem[r_rd_ptr[AW-1:0]].ch;
  assign evt_type    = r_mem[r_rd_ptr[AW-1:0]].typ;
  assign evt_dropped = r_dropped;

endmodule

// File: doc/button_events.md
# button_events

Converts the debounced button bus into discrete, timestamp-free button events for the control logic. Sits directly downstream of the debounce stage, in the same clock domain, so no input synchroniser is needed. Per channel it emits press, release, long-press and auto-repeat events. Events from all channels are merged into one small FIFO drained over a valid/ready handshake.

## Interface
- WIDTH, 6: number of button channels
- POLARITY, "LOW": "LOW" means active when buttons_in is 0; "HIGH" means active when buttons_in is 1
- LONG_TIMEOUT, 50000000: cycles held before the LONG event (must be ≥2)
- REPEAT_PERIOD, 10000000: cycles between REPEAT events after LONG; 0 disables repeat
- COUNT_WIDTH, 26: counter width; must hold max(LONG_TIMEOUT, REPEAT_PERIOD)
- FIFO_DEPTH, 4: event FIFO entries, power of 2, ≥2
- CH_WIDTH, 3: ceil(log2(WIDTH)), minimum 1

Ports:
- clk  input  1  system clock
- reset  input  1  reset; one clock; reset is synchronous and active-high
- buttons_in  input  WIDTH  debounced button levels
- pressed  output  WIDTH  per-channel level, 1 while the channel FSM is not IDLE
- evt_valid  output  1  FIFO head is valid
- evt_ready  input  1  consumer accepts the head
- evt_channel  output  CH_WIDTH  channel index of the head event
- evt_type  output  2  event type: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
- evt_dropped  output  1  sticky flag, set when any event is lost; cleared only by reset

## Operation
- Active level per channel: act[i] = (POLARITY=="LOW") ? ~buttons_in[i] : buttons_in[i].
- Per-channel FSM has states IDLE, PRESSED and HELD, plus a counter cnt[i].
  - IDLE: if act, go to PRESSED, set cnt=0 and raise PRESS.
  - PRESSED: if not act, go to IDLE and raise RELEASE. Otherwise, if cnt==LONG_TIMEOUT-1, go to HELD, set cnt=0 and raise LONG. Otherwise cnt+1.
  - HELD: if not act, go to IDLE and raise RELEASE. Otherwise, if REPEAT_PERIOD!=0 and cnt==REPEAT_PERIOD-1, set cnt=0 and raise REPEAT. Otherwise cnt+1.
  - The counter saturates; it never wraps. With REPEAT_PERIOD=0 it holds at 0 in HELD.
  - Release has priority over LONG and REPEAT in the same cycle.
- Each channel has a 1-entry pending slot holding its type.
  - A raised event loads the slot.
  - If the slot is still occupied and not being drained that cycle, the new event is discarded and evt_dropped is set.
- Merge arbiter, fixed priority, lowest channel index first:
  - Each cycle, when the FIFO is not full, it moves one pending slot into the FIFO as {channel, type}.
  - A slot drained in cycle N may be reloaded in cycle N.
- FIFO behaviour:
  - Show-ahead; evt_valid = not empty.
  - Pop on evt_valid && evt_ready.
  - No push when full, even if a pop occurs in the same cycle; the pending slot simply waits.
  - evt_channel and evt_type hold while evt_valid && !evt_ready.
- pressed[i] is a registered copy of (state != IDLE).

## Timing
- Reset values: all FSMs IDLE, counters 0, slots empty, FIFO empty, evt_valid=0, evt_channel=0, evt_type=0, pressed=0, evt_dropped=0.
- A channel active at the first edge after reset deassertion is a new press; it emits PRESS.
- Latency, where edge N is the first edge sampling act=1:
  - pressed rises after edge N.
  - The slot loads at edge N.
  - The FIFO write is at edge N+1, if the slot wins arbitration and the FIFO is not full.
  - evt_valid is high after edge N+1, so latency is 2 cycles.
- LONG is raised at edge N+LONG_TIMEOUT.
- REPEAT k (k≥1) is raised at edge N+LONG_TIMEOUT+k·REPEAT_PERIOD.
- RELEASE is raised at the first edge sampling act=0. pressed falls after that same edge.
- A press lasting exactly 1 cycle produces PRESS then RELEASE one cycle apart. If the slot has not drained in between, RELEASE is dropped.
- Simultaneous events on k channels drain over k cycles in ascending channel order. Worst-case slot residency is WIDTH cycles while the FIFO has space.
- Reset asserted mid-operation discards all FSM state, slots and FIFO contents at that edge. No RELEASE is emitted.

## Test plan
Bench parameters: WIDTH=6, POLARITY="LOW", LONG_TIMEOUT=8, REPEAT_PERIOD=4, FIFO_DEPTH=4, evt_ready=1 unless stated.
- Short press: ch2 low for 5 cycles -> {2,PRESS} valid 2 cycles after first low sample. Then {2,RELEASE}. No LONG. pressed[2] high for 5 cycles.
- Long with repeat: ch0 low for 20 cycles -> PRESS, LONG at +8, REPEAT at +12, +16 and +20 if still held, then RELEASE. Exactly 2 REPEATs for a 19-cycle hold.
- Simultaneous press: ch5, ch1 and ch3 go low on the same edge -> FIFO order ch1, ch3, ch5 on consecutive cycles. evt_dropped=0.
- Backpressure: evt_ready=0, 6 channels pressed then released -> FIFO fills with 4 entries and the slots hold the rest. The events that cannot fit are dropped and evt_dropped=1. After evt_ready=1, the surviving events arrive in order with no duplicates.
- REPEAT_PERIOD=0: hold ch4 for 30 cycles -> PRESS, LONG, RELEASE only.
- Reset mid-hold: assert reset while ch0 is in HELD -> next cycle pressed=0, evt_valid=0. Input still low at reset deassertion -> new PRESS at 2-cycle latency.
